// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement path: default reference
// clock and gate length, the divider width and the freq_calc state encoding.
package freq_meas_pkg;

    localparam longint unsigned CLK_FS_DEF    = 64'd100_000_000;
    localparam longint unsigned GATE_TIME_DEF = 64'd100;
    // Must be wider than 32 and hold CLK_FS*GATE_TIME without wrapping.
    localparam int              NUM_W_DEF     = 40;
    localparam int              FS_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp a wide unsigned quotient onto the 32-bit frequency output.
    function automatic logic [31:0] clamp_u32(input logic [63:0] q);
        if (q[63:32] != 32'd0) begin
            return 32'hFFFF_FFFF;
        end else begin
            return q[31:0];
        end
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// A start pulse loads the operands; done is high during the cycle whose
// closing edge performs the last of NUM_W steps, after which quotient holds
// the result until the next start.
module seq_divider #(
    parameter int NUM_W = 40,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [NUM_W-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    // The dividend register shifts left each step and receives the new
    // quotient bit at its LSB, so after NUM_W steps it holds the quotient.
    logic [NUM_W-1:0] dvd_r;
    logic [NUM_W-1:0] dvs_r;
    logic [NUM_W-1:0] rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic [NUM_W:0]   trial_s;
    logic             ge_s;
    logic             last_s;

    // Trial subtraction for the current step.
    always_comb begin
        trial_s = {rem_r, dvd_r[NUM_W-1]};
        ge_s    = (trial_s >= {1'b0, dvs_r});
        last_s  = run_r && (cnt_r == CNT_W'(NUM_W - 1));
    end

    // Operand load on start, then one shift-subtract step per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r <= '0;
            dvs_r <= '0;
            rem_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (start) begin
            dvd_r <= dividend;
            dvs_r <= {{(NUM_W - DEN_W){1'b0}}, divisor};
            rem_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
        end else if (run_r) begin
            dvd_r <= {dvd_r[NUM_W-2:0], ge_s};
            rem_r <= ge_s ? NUM_W'(trial_s - {1'b0, dvs_r}) : trial_s[NUM_W-1:0];
            cnt_r <= cnt_r + CNT_W'(1);
            run_r <= ~last_s;
        end else begin
            dvd_r <= dvd_r;
            dvs_r <= dvs_r;
            rem_r <= rem_r;
            cnt_r <= cnt_r;
            run_r <= run_r;
        end
    end

    assign quotient = dvd_r;
    assign done     = last_s;

endmodule

// File: rtl/freq_calc.sv
// Converts a reference-clock count taken over a fixed gate into a frequency
// in Hz: freq_hz = floor(CLK_FS*GATE_TIME / fs_cnt). A zero count bypasses
// the divider and reports div-by-zero; quotients above 32 bits saturate.
module freq_calc
    import freq_meas_pkg::*;
#(
    parameter longint unsigned CLK_FS    = CLK_FS_DEF,
    parameter longint unsigned GATE_TIME = GATE_TIME_DEF,
    parameter int              NUM_W     = NUM_W_DEF
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic [FS_W-1:0] fs_cnt,
    input  logic            measurement_end_flag,
    output logic [31:0]     freq_hz,
    output logic            freq_valid,
    output logic            busy,
    output logic            err_div0,
    output logic            err_sat,
    output logic            overrun
);

    localparam logic [NUM_W-1:0] DIVIDEND = NUM_W'(CLK_FS * GATE_TIME);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             div_start_s;
    logic             div_done_s;
    logic [NUM_W-1:0] quot_s;
    logic             div0_r;
    logic [31:0]      res_freq_s;
    logic             res_div0_s;
    logic             res_sat_s;
    logic [31:0]      freq_hz_r;
    logic             freq_valid_r;
    logic             busy_r;
    logic             err_div0_r;
    logic             err_sat_r;
    logic             overrun_r;

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (FS_W)
    ) u_div (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend (DIVIDEND),
        .divisor  (fs_cnt),
        .quotient (quot_s),
        .done     (div_done_s)
    );

    // Next-state logic and divider launch.
    always_comb begin
        state_nxt_s = state_r;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (measurement_end_flag) begin
                    if (fs_cnt == 32'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                        div_start_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result selection: div-by-zero takes priority over the divider output.
    always_comb begin
        res_freq_s = clamp_u32(64'(quot_s));
        res_sat_s  = (quot_s > NUM_W'(32'hFFFF_FFFF));
        res_div0_s = 1'b0;
        if (div0_r) begin
            res_freq_s = 32'hFFFF_FFFF;
            res_sat_s  = 1'b0;
            res_div0_s = 1'b1;
        end else begin
            res_div0_s = 1'b0;
        end
    end

    // State register, status outputs and result registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div0_r       <= 1'b0;
            freq_hz_r    <= 32'd0;
            freq_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            err_div0_r   <= 1'b0;
            err_sat_r    <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            overrun_r    <= measurement_end_flag && (state_r != ST_IDLE);
            freq_valid_r <= (state_r == ST_DONE);
            if ((state_r == ST_IDLE) && measurement_end_flag) begin
                div0_r <= (fs_cnt == 32'd0);
            end else begin
                div0_r <= div0_r;
            end
            if (state_r == ST_DONE) begin
                freq_hz_r  <= res_freq_s;
                err_div0_r <= res_div0_s;
                err_sat_r  <= res_sat_s;
            end else begin
                freq_hz_r  <= freq_hz_r;
                err_div0_r <= err_div0_r;
                err_sat_r  <= err_sat_r;
            end
        end
    end

    assign freq_hz    = freq_hz_r;
    assign freq_valid = freq_valid_r;
    assign busy       = busy_r;
    assign err_div0   = err_div0_r;
    assign err_sat    = err_sat_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: stimulus pushes expected results computed
// with plain 64-bit arithmetic, a negedge monitor pops and compares them.
module tb_freq_calc;

    localparam longint unsigned PROD = 64'd100_000_000 * 64'd100;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] fs_cnt  = 32'd0;
    logic        measurement_end_flag = 1'b0;
    logic [31:0] freq_hz;
    logic        freq_valid;
    logic        busy;
    logic        err_div0;
    logic        err_sat;
    logic        overrun;

    freq_calc dut (
        .sys_clk              (sys_clk),
        .rst_n                (rst_n),
        .fs_cnt               (fs_cnt),
        .measurement_end_flag (measurement_end_flag),
        .freq_hz              (freq_hz),
        .freq_valid           (freq_valid),
        .busy                 (busy),
        .err_div0             (err_div0),
        .err_sat              (err_sat),
        .overrun              (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] freq;
        logic        div0;
        logic        sat;
        longint      cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    longint      cyc         = 0;
    int          ovr_seen    = 0;
    int          ovr_exp     = 0;
    int          valid_seen  = 0;
    int          valid_exp   = 0;
    logic [31:0] last_freq   = 32'd0;
    logic        last_div0   = 1'b0;
    logic        last_sat    = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: the frequency is the gate product over the count, floored;
    // zero counts report div-by-zero, anything over 32 bits saturates.
    function automatic exp_t model(input logic [31:0] fs, input longint e0);
        exp_t            e;
        longint unsigned q;
        if (fs == 32'd0) begin
            e.freq = 32'hFFFF_FFFF; e.div0 = 1'b1; e.sat = 1'b0; e.cyc = e0 + 1;
        end else begin
            q = PROD / longint'(fs);
            e.div0 = 1'b0;
            e.cyc  = e0 + 41;
            if (q > 64'hFFFF_FFFF) begin
                e.freq = 32'hFFFF_FFFF; e.sat = 1'b1;
            end else begin
                e.freq = q[31:0]; e.sat = 1'b0;
            end
        end
        return e;
    endfunction

    // Monitor: reset values, result checks on freq_valid, hold checks otherwise.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!rst_n) begin
            last_freq = 32'd0; last_div0 = 1'b0; last_sat = 1'b0;
            check("reset_outputs", {freq_hz, freq_valid, busy, err_div0, err_sat, overrun}, 64'd0);
        end else if (freq_valid) begin
            valid_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("freq_hz", freq_hz, e.freq);
                check("err_div0", err_div0, e.div0);
                check("err_sat", err_sat, e.sat);
                check("latency_cycle", cyc, e.cyc);
                check("busy_at_valid", busy, 0);
                last_freq = e.freq; last_div0 = e.div0; last_sat = e.sat;
            end
        end else begin
            check("hold_outputs", {freq_hz, err_div0, err_sat}, {last_freq, last_div0, last_sat});
        end
        if (rst_n && overrun) ovr_seen++;
    end

    // Raise the flag now (between edges); the next rising edge is e0.
    task automatic pulse(input logic [31:0] fs);
        fs_cnt = fs;
        measurement_end_flag = 1'b1;
        sb_q.push_back(model(fs, cyc + 1));
        valid_exp++;
        @(posedge sys_clk); #1;
        measurement_end_flag = 1'b0;
        fs_cnt = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    task automatic issue(input logic [31:0] fs);
        @(posedge sys_clk); #1;
        pulse(fs);
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 150) begin
            @(negedge sys_clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1);
    end

    initial begin
        logic [31:0] dir_vals[8];
        int          hit;
        dir_vals = '{32'd200, 32'd7, 32'd3, 32'd2, 32'd0, 32'd1000, 32'd1, 32'hFFFF_FFFF};

        // Reset state, checked asynchronously and by the monitor.
        #2;
        check("reset_freq_hz", freq_hz, 0);
        check("reset_flags", {freq_valid, busy, err_div0, err_sat, overrun}, 0);
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;

        // Directed values: nominal, truncation, largest unsaturated, saturation,
        // div-by-zero and the extremes of the count range.
        foreach (dir_vals[i]) begin
            issue(dir_vals[i]);
            drain();
        end

        // Second flag ten cycles into a division is ignored and flagged.
        issue(32'd200);
        repeat (9) @(posedge sys_clk);
        #1;
        fs_cnt = 32'd5;
        measurement_end_flag = 1'b1;
        ovr_exp++;
        @(posedge sys_clk); #1;
        measurement_end_flag = 1'b0;
        check("overrun_high", overrun, 1);
        @(posedge sys_clk); #1;
        check("overrun_one_cycle", overrun, 0);
        drain();
        repeat (50) @(posedge sys_clk);
        check("valid_count_after_overrun", valid_seen, valid_exp);

        // Back-to-back: next flag in the very cycle freq_valid is high.
        issue(32'd200);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (freq_valid) begin
                hit = 1;
                break;
            end
        end
        check("b2b_valid_seen", hit, 1);
        pulse(32'd7);
        drain();

        // Reset twenty cycles into a division aborts it silently.
        @(posedge sys_clk); #1;
        fs_cnt = 32'd1234;
        measurement_end_flag = 1'b1;
        @(posedge sys_clk); #1;
        measurement_end_flag = 1'b0;
        repeat (19) @(posedge sys_clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {freq_hz, freq_valid, busy, err_div0, err_sat, overrun}, 0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge sys_clk);
        check("valid_count_after_reset", valid_seen, valid_exp);
        issue(32'd1000);
        drain();

        // Randomised counts across small, mid, full-range and zero values.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] v;
            case ($urandom_range(0, 4))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 10);
                2:       v = $urandom_range(1, 100000);
                3:       v = 32'd0;
                default: v = $urandom_range(2, 4);
            endcase
            issue(v);
            drain();
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end

        repeat (5) @(posedge sys_clk);
        #1;
        check("valid_count_total", valid_seen, valid_exp);
        check("overrun_count_total", ovr_seen, ovr_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_calc.md
FREQ_CALC -- requirements
Module: freq_calc

Interface
REQ-001 SHALL have parameter CLK_FS, default 100_000_000, the reference clock frequency in Hz.
REQ-002 SHALL have parameter GATE_TIME, default 100, the gate length in measured-signal cycles used by the upstream counter.
REQ-003 SHALL have parameter NUM_W, default 40, the dividend/quotient width; the design SHALL require CLK_FS*GATE_TIME < 2^NUM_W.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port fs_cnt, input, 32 bits: reference-clock count over one gate, from the upstream counter.
REQ-007 SHALL have port measurement_end_flag, input, 1 bit: one-cycle pulse; fs_cnt is stable while it is high.
REQ-008 SHALL have port freq_hz, output, 32 bits: measured frequency in Hz.
REQ-009 SHALL have port freq_valid, output, 1 bit: one-cycle pulse marking a new freq_hz.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port err_div0, output, 1 bit: the last result had fs_cnt == 0.
REQ-012 SHALL have port err_sat, output, 1 bit: the last result was saturated.
REQ-013 SHALL have port overrun, output, 1 bit: one-cycle pulse when a flag is dropped while busy.

Function
REQ-014 SHALL compute freq_hz = floor(CLK_FS*GATE_TIME / fs_cnt), using an unsigned NUM_W-bit dividend and a 32-bit divisor zero-extended to NUM_W bits.
REQ-015 SHALL implement an FSM with states IDLE, DIV and DONE; the reset state SHALL be IDLE.
REQ-016 In IDLE, when measurement_end_flag is high and fs_cnt != 0 at an edge (call it e0), the block SHALL capture fs_cnt, load the dividend, clear the remainder and iteration counter, and enter DIV.
REQ-017 DIV SHALL perform one restoring shift-subtract step per clock and produce exactly one quotient bit per step, MSB first.
REQ-018 The block SHALL complete NUM_W steps on edges e1..eNUM_W and then enter DONE.
REQ-019 At edge eNUM_W+1 the block SHALL register freq_hz and the error flags, raise freq_valid for one cycle, and return to IDLE.
REQ-020 With default parameters, freq_valid SHALL therefore be high 41 edges after e0.
REQ-021 If the quotient is >= 2^32, freq_hz SHALL be 0xFFFF_FFFF, err_sat = 1 and err_div0 = 0.
REQ-022 Otherwise freq_hz SHALL be the low 32 bits of the quotient, with err_sat = 0 and err_div0 = 0.
REQ-023 In IDLE, when the flag is high and fs_cnt == 0 at e0, the block SHALL enter DONE directly.
REQ-024 In that case, at e1 it SHALL output freq_hz = 0xFFFF_FFFF, err_div0 = 1, err_sat = 0 and freq_valid = 1.
REQ-025 A flag arriving in DIV or DONE SHALL be ignored and SHALL pulse overrun for one cycle; the result in progress SHALL not be affected.
REQ-026 freq_hz, err_div0 and err_sat SHALL hold their values between freq_valid pulses.
REQ-027 A flag in the same cycle that freq_valid is high, with the FSM back in IDLE, SHALL be accepted normally, so back-to-back operation is allowed.
REQ-028 The block SHALL apply no backpressure; the consumer SHALL sample freq_hz on freq_valid.

Reset
REQ-029 While rst_n is low: state = IDLE; freq_hz = 0; freq_valid, busy, err_div0, err_sat and overrun = 0; the internal dividend, remainder, divisor and counter = 0.
REQ-030 Reset asserted mid-division SHALL abort the division with no freq_valid issued.
REQ-031 The first flag after rst_n deasserts SHALL start a fresh computation.

Structure
REQ-032 The shared package freq_meas_pkg SHALL hold the CLK_FS and GATE_TIME defaults, NUM_W, and the FSM state encoding.
REQ-033 The divider SHALL be a sub-module seq_divider: an unsigned restoring divider with start/done handshake, parameterised widths and a fixed latency of NUM_W cycles.
REQ-034 freq_calc SHALL hold the FSM, the special-case handling and the output registers.

Verification
REQ-035 fs_cnt = 200 with a flag pulse SHALL give freq_hz = 50_000_000 and no error flags, with freq_valid 41 cycles after the flag.
REQ-036 fs_cnt = 7 SHALL give freq_hz = 1_428_571_428, checking truncation.
REQ-037 fs_cnt = 3 SHALL give freq_hz = 3_333_333_333 with no saturation; fs_cnt = 2 SHALL give freq_hz = 0xFFFF_FFFF with err_sat = 1.
REQ-038 fs_cnt = 0 SHALL give freq_valid 1 cycle later, with freq_hz = 0xFFFF_FFFF and err_div0 = 1.
REQ-039 A second flag 10 cycles after the first SHALL pulse overrun, leave the first result correct, and produce no second freq_valid.
REQ-040 rst_n pulsed low at cycle 20 of a division SHALL produce no freq_valid and return all outputs to 0; a following flag with fs_cnt = 1000 SHALL give 10_000_000.
